// File: rtl/divider_32bit_pkg.sv
// Shared definitions for the multi-cycle restoring divider (MIPS DIV/DIVU).
// Width is fixed at 32 for MIPS; the iteration counter must be able to hold WIDTH.
package divider_32bit_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    // Number of DIVIDE iterations, one quotient bit per iteration.
    localparam logic [CNT_W-1:0] ITER_COUNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W     = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_FINISH = 2'd2
    } div_state_e;

    // Two's-complement negation used for operand magnitudes and result signs.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

endpackage

// File: rtl/divider_32bit_subtractor.sv
// Combinational a - b with borrow out, formed as a + ~b + 1 on a 32-bit adder
// structure. borrow_out is the inverted adder carry.
module subtractor_32bit
    import divider_32bit_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    logic [WIDTH:0] sum_s;

    assign sum_s      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign diff       = sum_s[WIDTH-1:0];
    assign borrow_out = ~sum_s[WIDTH];

endmodule

// File: rtl/divider_32bit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: IDLE -> DIVIDE (32 iterations)
// -> FINISH. Quotient goes to LO, remainder to HI; done pulses once per result.
// Optional feature macro: DIV_ZERO_DETECT_EN (adds div_by_zero and a 2-cycle
// fast path for a zero divisor).
module divider_32bit
    import divider_32bit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic             div_by_zero
`endif
);

    div_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic             signed_r;
    logic             dvd_neg_r;
    logic             dvs_neg_r;
`ifdef DIV_ZERO_DETECT_EN
    logic             dz_r;
`endif

    logic             dvd_neg_s;
    logic             dvs_neg_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH-1:0] diff_s;
    logic             borrow_s;
    logic             take_s;
    logic [WIDTH-1:0] quo_fin_s;
    logic [WIDTH-1:0] rem_fin_s;

    // Operand signs only matter for DIV; DIVU treats both as unsigned magnitudes.
    assign dvd_neg_s = is_signed & dividend[WIDTH-1];
    assign dvs_neg_s = is_signed & divisor[WIDTH-1];
    assign dvd_mag_s = dvd_neg_s ? negate(dividend) : dividend;
    assign dvs_mag_s = dvs_neg_s ? negate(divisor) : divisor;

    // Shifted partial remainder is WIDTH+1 bits; a set top bit means it already
    // exceeds any 32-bit divisor, so the trial subtraction cannot borrow.
    assign shift_s = {rem_r, quo_r[WIDTH-1]};
    assign take_s  = shift_s[WIDTH] | ~borrow_s;

    subtractor_32bit u_trial_sub (
        .a          (shift_s[WIDTH-1:0]),
        .b          (dvs_r),
        .diff       (diff_s),
        .borrow_out (borrow_s)
    );

    // Sign fix-up: truncation toward zero, remainder follows the dividend sign.
    assign quo_fin_s = (signed_r & (dvd_neg_r ^ dvs_neg_r)) ? negate(quo_r) : quo_r;
    assign rem_fin_s = dvd_neg_r ? negate(rem_r) : rem_r;

    // Divider control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_r       <= '0;
            signed_r    <= 1'b0;
            dvd_neg_r   <= 1'b0;
            dvs_neg_r   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz_r        <= 1'b0;
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        signed_r  <= is_signed;
                        dvd_neg_r <= dvd_neg_s;
                        dvs_neg_r <= dvs_neg_s;
                        quo_r     <= dvd_mag_s;
                        dvs_r     <= dvs_mag_s;
                        rem_r     <= '0;
                        cnt_r     <= ITER_COUNT;
                        busy      <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                        div_by_zero <= 1'b0;
                        dz_r        <= (divisor == ZERO_W);
                        state_r     <= (divisor == ZERO_W) ? ST_FINISH : ST_DIVIDE;
`else
                        state_r   <= ST_DIVIDE;
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_DIVIDE: begin
                    rem_r <= take_s ? diff_s : shift_s[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], take_s};
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_FINISH;
                    end else begin
                        state_r <= ST_DIVIDE;
                    end
                end
                ST_FINISH: begin
`ifdef DIV_ZERO_DETECT_EN
                    if (dz_r) begin
                        // DIVIDE was skipped, so quo_r still holds |dividend|.
                        quotient    <= ONES_W;
                        remainder   <= dvd_neg_r ? negate(quo_r) : quo_r;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= quo_fin_s;
                        remainder   <= rem_fin_s;
                    end
`else
                    quotient  <= quo_fin_s;
                    remainder <= rem_fin_s;
`endif
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32bit.sv
// Scoreboard bench for divider_32bit: a driver issues divisions and pushes the
// arithmetic expectation; an independent monitor checks every done pulse,
// latency, busy window and held outputs.
module tb_divider_32bit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = 32'h0;
    logic [31:0] divisor = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic        div_by_zero;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] held_q = 32'h0;
    logic [31:0] held_r = 32'h0;
    logic        held_dz = 1'b0;

    divider_32bit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
`ifdef DIV_ZERO_DETECT_EN
        ,
        .div_by_zero(div_by_zero)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: plain integer division; zero divisor per the architectural rules.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint la, lb, lq, lr;
        e.dz  = 1'b0;
        e.lat = 33;
        e.acc = 0;
        if (b == 32'h0) begin
`ifdef DIV_ZERO_DETECT_EN
            e.q   = 32'hFFFF_FFFF;
            e.dz  = 1'b1;
            e.lat = 1;
`else
            e.q   = (s && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif
            e.r = a;
        end else begin
            if (s) begin
                la = $signed(a);
                lb = $signed(b);
            end else begin
                la = {32'h0, a};
                lb = {32'h0, b};
            end
            lq  = la / lb;
            lr  = la % lb;
            e.q = lq[31:0];
            e.r = lr[31:0];
        end
        return e;
    endfunction

    // Monitor: busy window, done timing, result values and held outputs.
    always @(negedge clk) begin
        if (!reset) begin
            logic eb;
            eb = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].acc + sb[0].lat);
            check("busy", {31'h0, busy}, {31'h0, eb});
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", cyc - e.acc, e.lat);
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
`ifdef DIV_ZERO_DETECT_EN
                    check("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.dz});
`endif
                    held_q  = e.q;
                    held_r  = e.r;
                    held_dz = e.dz;
                end
            end else begin
                check("quotient_hold", quotient, held_q);
                check("remainder_hold", remainder, held_r);
                if (sb.size() > 0 && cyc >= sb[0].acc + sb[0].lat) begin
                    check("missing_done", 32'h0, 32'h1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            check("idle_timeout", 32'h1, 32'h0);
        end else begin
            start     = 1'b1;
            dividend  = a;
            divisor   = b;
            is_signed = s;
            @(posedge clk);
            #1;
            start     = 1'b0;
            dividend  = $urandom;
            divisor   = $urandom;
            is_signed = 1'($urandom_range(0, 1));
            e = model(a, b, s);
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    // Start pulses with junk operands while busy; they must be ignored.
    task automatic noise(input int n);
        repeat (n) begin
            @(negedge clk);
            if (busy) begin
                start     = 1'b1;
                dividend  = $urandom;
                divisor   = $urandom;
                is_signed = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", 32'h1, 32'h0);
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] a, b;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_quotient", quotient, 32'h0);
        check("reset_remainder", remainder, 32'h0);
        #2 reset = 1'b0;

        issue(32'd100, 32'd7, 1'b0);
        issue(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        issue(32'hFFFF_FFFB, 32'h0000_0000, 1'b1);
        issue(32'hFFFF_FFFB, 32'h0000_0000, 1'b0);
        issue(32'h8000_0000, 32'h8000_0001, 1'b0);
        issue(32'h0000_1234, 32'h0000_0010, 1'b0);
        noise(12);
        issue(32'h8765_4321, 32'hFFFF_FFF3, 1'b1);
        noise(40);
        drain();

        // Asynchronous reset in the middle of an iteration.
        issue(32'd1000, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_done", {31'h0, done}, 32'h0);
        check("arst_quotient", quotient, 32'h0);
        check("arst_remainder", remainder, 32'h0);
`ifdef DIV_ZERO_DETECT_EN
        check("arst_div_by_zero", {31'h0, div_by_zero}, 32'h0);
`endif
        sb.delete();
        held_q  = 32'h0;
        held_r  = 32'h0;
        held_dz = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        issue(32'd100, 32'd7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            issue(a, b, 1'($urandom_range(0, 1)));
            if (i % 8 == 3) noise(5);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
